seg_drive: RTL and testbench



---
 rtl/seg_drive.sv | 115 +++++++++++
 tb/tb_seg_drive.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg_drive.sv
// Seven-segment output stage: captures the scanner's digit/glyph, blanks for
// BLANK_CYCLES after every change, decodes the glyph and PWM-gates the pins.
module seg_drive #(
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          dig,
  input  logic [4:0]          num,
  input  logic [PWM_BITS-1:0] bright,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  typedef enum logic {BLANK, SHOW} state_e;

  localparam logic [7:0]          BCNT_INIT = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);
  localparam logic [4:0]          NUM_BLANK = 5'd20;
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

  state_e              state_q, state_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic [3:0]          cap_dig_q, cap_dig_d;
  logic [4:0]          cap_num_q, cap_num_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                chg;
  logic                pwm_on;

  function automatic logic [6:0] decode(input logic [4:0] code);
    unique case (code)
      5'd0:    decode = 7'h3F;
      5'd1:    decode = 7'h06;
      5'd2:    decode = 7'h5B;
      5'd3:    decode = 7'h4F;
      5'd4:    decode = 7'h66;
      5'd5:    decode = 7'h6D;
      5'd6:    decode = 7'h7D;
      5'd7:    decode = 7'h07;
      5'd8:    decode = 7'h7F;
      5'd9:    decode = 7'h6F;
      5'd10:   decode = 7'h77;
      5'd11:   decode = 7'h7C;
      5'd12:   decode = 7'h39;
      5'd13:   decode = 7'h5E;
      5'd14:   decode = 7'h79;
      5'd15:   decode = 7'h71;
      5'd16:   decode = 7'h40;
      default: decode = 7'h00;
    endcase
  endfunction

  assign chg    = (dig != cap_dig_q) || (num != cap_num_q);
  assign pwm_on = (bright == PWM_MAX) || (pwm_cnt_q < bright);

  // NOTE: every register, including the output pins, takes its reset value
  // asynchronously so the display goes dark the instant RST rises.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= BLANK;
      bcnt_q    <= BCNT_INIT;
      cap_dig_q <= 4'b0000;
      cap_num_q <= NUM_BLANK;
      pwm_cnt_q <= '0;
      an_q      <= 4'b0000;
      seg_q     <= 7'h00;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      cap_dig_q <= cap_dig_d;
      cap_num_q <= cap_num_d;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    cap_dig_d = cap_dig_q;
    cap_num_d = cap_num_q;
    if (chg) begin
      cap_dig_d = dig;
      cap_num_d = num;
      if (BLANK_CYCLES == 0) begin
        state_d = SHOW;
      end else begin
        state_d = BLANK;
        bcnt_d  = BCNT_INIT;
      end
    end else if (state_q == BLANK) begin
      if (bcnt_q == 8'd0) state_d = SHOW;
      else                bcnt_d  = bcnt_q - 8'd1;
    end
  end

  // Outputs look ahead at next-state so a change darkens the pins on its own edge.
  always_comb begin
    an_d  = 4'b0000;
    seg_d = 7'h00;
    if (state_d == SHOW && $onehot(cap_dig_d) && pwm_on) begin
      an_d  = cap_dig_d;
      seg_d = decode(cap_num_d);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_drive.sv
// Self-checking bench for seg_drive: a cycle-level model based on "age since
// last capture" plus directed scenarios with literal expectations.
module tb_seg_drive;

  localparam int BLANK = 4;
  localparam int PB    = 4;
  localparam int PMOD  = 1 << PB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [3:0]    dig = 4'b0000;
  logic [4:0]    num = 5'd20;
  logic [PB-1:0] bright = '1;
  logic [3:0]    an;
  logic [6:0]    seg;

  int n_cmp = 0;
  int n_bad = 0;

  seg_drive #(.BLANK_CYCLES(BLANK), .PWM_BITS(PB)) dut (
    .CLK(CLK), .RST(RST), .dig(dig), .num(num), .bright(bright), .an(an), .seg(seg)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Glyph table written out from the display legend.
  logic [6:0] glyph [32];
  initial begin
    logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 32; i++) glyph[i] = (i < 16) ? hex[i] : ((i == 16) ? 7'h40 : 7'h00);
  end

  // Model: outputs lit only once BLANK edges have passed since the capture,
  // the digit is one-hot, and the free-running cycle count is under bright.
  logic [3:0] m_dig;
  logic [4:0] m_num;
  int         m_age, m_cyc;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  bit         on;

  always @(posedge CLK) begin
    if (RST) begin
      m_dig = 4'b0000; m_num = 5'd20; m_age = 0; m_cyc = 0;
      exp_an = 4'b0000; exp_seg = 7'h00;
    end else begin
      if (dig !== m_dig || num !== m_num) begin
        m_dig = dig; m_num = num; m_age = 0;
      end else if (m_age < 100000) begin
        m_age++;
      end
      on = (int'(bright) == PMOD - 1) || ((m_cyc % PMOD) < int'(bright));
      if (m_age >= BLANK && $countones(m_dig) == 1 && on) begin
        exp_an = m_dig; exp_seg = glyph[m_num];
      end else begin
        exp_an = 4'b0000; exp_seg = 7'h00;
      end
      m_cyc++;
    end
    #1;
    check("model_an", 32'(an), 32'(exp_an));
    check("model_seg", 32'(seg), 32'(exp_seg));
  end

  task automatic run(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_out(input string name, input logic [3:0] a, input logic [6:0] s);
    check({name, "_an"}, 32'(an), 32'(a));
    check({name, "_seg"}, 32'(seg), 32'(s));
  endtask

  task automatic count_lit(input int n, output int lit);
    lit = 0;
    repeat (n) begin
      @(negedge CLK);
      if (an != 4'b0000) begin
        lit++;
        check("pwm_seg", 32'(seg), 32'h40);
      end
    end
  endtask

  typedef struct { logic [3:0] d; logic [4:0] n; logic [6:0] s; } scan_t;
  scan_t scan [4] = '{'{4'b0001, 5'd20, 7'h00}, '{4'b0010, 5'd20, 7'h00},
                      '{4'b0100, 5'd10, 7'h77}, '{4'b1000, 5'd3,  7'h4F}};

  initial begin
    int lit;
    run(3);
    expect_out("reset", 4'b0000, 7'h00);
    RST = 1'b0;
    run(6);
    expect_out("idle_blank_code", 4'b0000, 7'h00);

    // Single capture: 4 dark cycles, then 6D on digit 0.
    dig = 4'b0001; num = 5'd5; bright = '1;
    run(4);
    expect_out("first_gap", 4'b0000, 7'h00);
    run(1);
    expect_out("first_show", 4'b0001, 7'h6D);
    run(10);
    expect_out("first_hold", 4'b0001, 7'h6D);

    // Scan sequence; the model guards every gap cycle.
    for (int i = 0; i < 4; i++) begin
      dig = scan[i].d; num = scan[i].n;
      run(2);
      expect_out("scan_gap", 4'b0000, 7'h00);
      run(62);
      expect_out("scan_show", scan[i].d, scan[i].s);
    end

    // PWM: bright=4 lights 4 of any 16 consecutive cycles; bright=0 none.
    dig = 4'b0100; num = 5'd16; bright = 4'd4;
    run(8);
    count_lit(16, lit);
    check("pwm_lit4", 32'(lit), 32'd4);
    bright = 4'd0;
    run(1);
    count_lit(16, lit);
    check("pwm_lit0", 32'(lit), 32'd0);

    // Change at bcnt=1 restarts the blank from the second change.
    bright = '1; dig = 4'b0010; num = 5'd2;
    run(3);
    num = 5'd3;
    run(2);
    expect_out("restart_gap_mid", 4'b0000, 7'h00);
    run(2);
    expect_out("restart_gap_end", 4'b0000, 7'h00);
    run(1);
    expect_out("restart_show", 4'b0010, 7'h4F);

    // Non-one-hot digits stay dark.
    dig = 4'b0011; num = 5'd8;
    count_lit(40, lit);
    check("multi_hot_dark", 32'(lit), 32'd0);
    dig = 4'b0000; num = 5'd16;
    count_lit(20, lit);
    check("zero_dig_dark", 32'(lit), 32'd0);

    // Async reset mid-SHOW, then recapture after release.
    dig = 4'b1000; num = 5'd7;
    run(10);
    expect_out("pre_reset_show", 4'b1000, 7'h07);
    #2 RST = 1'b1; num = 5'd1;
    #1 expect_out("async_reset", 4'b0000, 7'h00);
    run(2);
    RST = 1'b0;
    run(4);
    expect_out("post_reset_gap", 4'b0000, 7'h00);
    run(1);
    expect_out("post_reset_show", 4'b1000, 7'h06);
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
